// File: rtl/vga_feeder_pkg.sv
// Shared types and constants for the VGA pixel feeder.
package vga_feeder_pkg;

  localparam int DEFAULT_H_ACTIVE = 640;
  localparam int DEFAULT_V_ACTIVE = 480;
  localparam int PIXEL_W          = 24;

  typedef enum logic [1:0] {
    SEARCH     = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic                sof;
    logic [PIXEL_W-1:0]  rgb;
  } pixel_t;

  function automatic logic [7:0] rgb_red(input logic [PIXEL_W-1:0] rgb);
    return rgb[23:16];
  endfunction

  function automatic logic [7:0] rgb_green(input logic [PIXEL_W-1:0] rgb);
    return rgb[15:8];
  endfunction

  function automatic logic [7:0] rgb_blue(input logic [PIXEL_W-1:0] rgb);
    return rgb[7:0];
  endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
module vga_pixel_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Advance the read and write pointers on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers a frame-tagged RGB888 stream and aligns it to the VGA raster.
// Optional statistics counters are enabled by defining VGA_FEEDER_STATS_EN.
module vga_pixel_feeder
  import vga_feeder_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 1024,
  parameter int H_ACTIVE = DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE = DEFAULT_V_ACTIVE
) (
  input  logic                     i_VGA_CLK,
  input  logic                     i_rst,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic [DATA_W-1:0]        i_s_data,
  input  logic                     i_s_sof,
  input  logic                     i_de,
  input  logic                     i_frame_start,
  output logic [7:0]               o_VGA_R,
  output logic [7:0]               o_VGA_G,
  output logic [7:0]               o_VGA_B,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_locked,
  output logic                     o_underflow
`ifdef VGA_FEEDER_STATS_EN
  ,
  output logic [15:0]              o_frame_cnt,
  output logic [15:0]              o_resync_cnt
`endif
);

  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS);

  feeder_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              underflow_q, underflow_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  pixel_t            head;
  logic              frame_done;
  logic              resync;

  assign o_s_ready = ~fifo_full & ~i_rst;
  assign fifo_push = i_s_valid && o_s_ready;
  assign head      = fifo_head;

  vga_pixel_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_VGA_CLK),
    .rst       (i_rst),
    .push      (fifo_push),
    .push_data ({i_s_sof, i_s_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_level)
  );

  // Alignment FSM: frame_start is resolved before the display-enable request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_eff     = cnt_q;
    rgb_d       = '0;
    underflow_d = underflow_q;
    fifo_pop    = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      SEARCH: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          if (head.sof) begin
            state_d = WAIT_FRAME;
          end else begin
            fifo_pop = 1'b1;
          end
        end
      end
      WAIT_FRAME: begin
        if (i_frame_start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (i_frame_start) begin
          if (cnt_q == FRAME_LAST || cnt_q == '0) begin
            frame_done = (cnt_q == FRAME_LAST);
            cnt_eff    = '0;
            cnt_d      = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        if (state_d == RUN && i_de) begin
          if (cnt_eff == FRAME_LAST) begin
            state_d = SEARCH;
          end else if (fifo_empty) begin
            underflow_d = 1'b1;
            state_d     = SEARCH;
          end else if (head.sof && cnt_eff != '0) begin
            state_d = SEARCH;
          end else begin
            fifo_pop = 1'b1;
            rgb_d    = head.rgb;
            cnt_d    = cnt_eff + CNT_W'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign resync = (state_q == RUN) && (state_d == SEARCH);

  // State, pixel counter, registered RGB and sticky underflow flag.
  always_ff @(posedge i_VGA_CLK or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= SEARCH;
      cnt_q       <= '0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_VGA_R     = rgb_red(rgb_q);
  assign o_VGA_G     = rgb_green(rgb_q);
  assign o_VGA_B     = rgb_blue(rgb_q);
  assign o_locked    = (state_q == RUN);
  assign o_underflow = underflow_q;

`ifdef VGA_FEEDER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] resync_cnt_q, resync_cnt_d;

  // Completed-frame counter wraps; resync counter saturates.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    resync_cnt_d = resync_cnt_q;
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (resync && resync_cnt_q != 16'hFFFF) begin
      resync_cnt_d = resync_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_VGA_CLK or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q  <= '0;
      resync_cnt_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  assign o_frame_cnt  = frame_cnt_q;
  assign o_resync_cnt = resync_cnt_q;
`endif

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Self-checking bench for vga_pixel_feeder on a reduced 8x4 raster.
module tb_vga_pixel_feeder;
  import vga_feeder_pkg::*;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = H * V;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [23:0]   s_data;
  logic          s_sof;
  logic          de;
  logic          frame_start;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic [LW-1:0] level;
  logic          locked;
  logic          underflow;
`ifdef VGA_FEEDER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   resync_cnt;
`endif
  logic [23:0]   rgb_out;

  pixel_t        src_q[$];
  logic [23:0]   frame_q[$];
  int            push_count;
  int            test_count = 0;
  int            fail_count = 0;

  assign rgb_out = {vga_r, vga_g, vga_b};

  always #5 clk = ~clk;

  vga_pixel_feeder #(
    .DATA_W   (24),
    .DEPTH    (DEPTH),
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .i_VGA_CLK     (clk),
    .i_rst         (rst),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .i_s_data      (s_data),
    .i_s_sof       (s_sof),
    .i_de          (de),
    .i_frame_start (frame_start),
    .o_VGA_R       (vga_r),
    .o_VGA_G       (vga_g),
    .o_VGA_B       (vga_b),
    .o_level       (level),
    .o_locked      (locked),
    .o_underflow   (underflow)
`ifdef VGA_FEEDER_STATS_EN
    ,
    .o_frame_cnt   (frame_cnt),
    .o_resync_cnt  (resync_cnt)
`endif
  );

  // One clock of stimulus: raster inputs as given, upstream pushes from src_q.
  task automatic cycle(input logic de_in, input logic fs_in);
    logic acc;
    de          = de_in;
    frame_start = fs_in;
    if (src_q.size() != 0) begin
      s_valid = 1'b1;
      s_sof   = src_q[0].sof;
      s_data  = src_q[0].rgb;
    end else begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = '0;
    end
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      void'(src_q.pop_front());
      push_count++;
    end
    de          = 1'b0;
    frame_start = 1'b0;
    s_valid     = 1'b0;
  endtask

  // Queue an n-pixel frame (sof on pixel 0) and remember what should be shown.
  task automatic queue_frame(input int n, input bit use_index);
    logic [23:0] d;
    for (int i = 0; i < n; i++) begin
      d = use_index ? 24'(i) : 24'($urandom);
      src_q.push_back(pixel_t'{sof: (i == 0), rgb: d});
      frame_q.push_back(d);
    end
  endtask

  // Idle until the FIFO is full or the source runs dry, bounded.
  task automatic fill(input string name);
    int n = 0;
    while (level != LW'(DEPTH) && src_q.size() != 0 && n < 80) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    if (n >= 80) begin
      test_count++;
      fail_count++;
      $display("[TB] FAIL %s_fill_timeout: level=%0d after %0d cycles", name, level, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; de = 1'b0; frame_start = 1'b0;
    src_q.delete();
    frame_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    do_reset();
    test_count++;
    if (level !== '0 || s_ready !== 1'b1 || locked !== 1'b0 || rgb_out !== '0 || underflow !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_initial: level=%0d ready=%b locked=%b rgb=%h uf=%b, want 0/1/0/0/0",
               level, s_ready, locked, rgb_out, underflow);
    end
    queue_frame(7, 1'b0);
    fill("reset");
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    exp = frame_q[1];
    test_count++;
    if (level !== LW'(5) || locked !== 1'b1 || rgb_out !== exp) begin
      fail_count++;
      $display("[TB] FAIL reset_prestate: level=%0d locked=%b rgb=%h, want 5/1/%h", level, locked, rgb_out, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    test_count++;
    if (level !== '0 || rgb_out !== '0 || locked !== 1'b0 || s_ready !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_async: level=%0d rgb=%h locked=%b ready=%b, want all 0",
               level, rgb_out, locked, s_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_count++;
    if (s_ready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", s_ready);
    end
    src_q.delete();
    frame_q.delete();
  endtask

  task automatic test_frame();
    logic [23:0] exp;
    int gap;
    do_reset();
    queue_frame(FRAME, 1'b1);
    fill("frame");
    test_count++;
    if (locked !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL frame_prelock: locked=%b want 0", locked);
    end
    cycle(1'b0, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cycle(1'b0, 1'b0);
        test_count++;
        if (rgb_out !== '0) begin
          fail_count++;
          $display("[TB] FAIL frame_idle_rgb: pixel %0d got %h want 0", k, rgb_out);
        end
      end
      cycle(1'b1, 1'b0);
      exp = frame_q.pop_front();
      test_count++;
      if (rgb_out !== exp || locked !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL frame_pixel: idx %0d rgb=%h locked=%b want %h/1", k, rgb_out, locked, exp);
      end
    end
    test_count++;
    if (underflow !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL frame_underflow: got %b want 0", underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    queue_frame(FRAME, 1'b0);
    fill("b2b");
    for (int k = 0; k < FRAME; k++) begin
      cycle(1'b1, (k == 0));
      exp = frame_q.pop_front();
      test_count++;
      if (rgb_out !== exp || locked !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL b2b_pixel: idx %0d rgb=%h locked=%b want %h/1", k, rgb_out, locked, exp);
      end
    end
`ifdef VGA_FEEDER_STATS_EN
    test_count++;
    if (frame_cnt !== 16'd1 || resync_cnt !== 16'd0) begin
      fail_count++;
      $display("[TB] FAIL b2b_stats: frame_cnt=%0d resync_cnt=%0d want 1/0", frame_cnt, resync_cnt);
    end
`endif
  endtask

  task automatic test_junk();
    logic [23:0] exp;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      src_q.push_back(pixel_t'{sof: 1'b0, rgb: 24'($urandom)});
    end
    queue_frame(FRAME, 1'b0);
    fill("junk");
    cycle(1'b0, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      cycle(1'b1, 1'b0);
      exp = frame_q.pop_front();
      test_count++;
      if (rgb_out !== exp) begin
        fail_count++;
        $display("[TB] FAIL junk_pixel: idx %0d rgb=%h want %h", k, rgb_out, exp);
      end
    end
  endtask

  task automatic test_underflow();
    logic [23:0] exp;
    do_reset();
    queue_frame(20, 1'b0);
    fill("uf");
    cycle(1'b0, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      cycle(1'b1, 1'b0);
      exp = (k < 20) ? frame_q.pop_front() : 24'h0;
      test_count++;
      if (rgb_out !== exp) begin
        fail_count++;
        $display("[TB] FAIL uf_pixel: idx %0d rgb=%h want %h", k, rgb_out, exp);
      end
    end
    test_count++;
    if (underflow !== 1'b1 || locked !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL uf_flags: underflow=%b locked=%b want 1/0", underflow, locked);
    end
    queue_frame(FRAME, 1'b0);
    fill("uf_recover");
    cycle(1'b0, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      cycle(1'b1, 1'b0);
      exp = frame_q.pop_front();
      test_count++;
      if (rgb_out !== exp || locked !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL uf_recover_pixel: idx %0d rgb=%h locked=%b want %h/1", k, rgb_out, locked, exp);
      end
    end
    test_count++;
    if (underflow !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL uf_sticky: got %b want 1", underflow);
    end
  endtask

  task automatic test_full();
    logic [23:0] words[40];
    int n = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      words[i] = 24'($urandom);
      src_q.push_back(pixel_t'{sof: (i == 0), rgb: words[i]});
    end
    push_count = 0;
    while (s_ready === 1'b1 && n < 40) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    test_count++;
    if (push_count !== 16 || level !== LW'(DEPTH) || s_ready !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL full_fill: pushes=%0d level=%0d ready=%b want 16/16/0", push_count, level, s_ready);
    end
    src_q.delete();
    cycle(1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 1'b0);
      test_count++;
      if (rgb_out !== words[k]) begin
        fail_count++;
        $display("[TB] FAIL full_drain: idx %0d rgb=%h want %h", k, rgb_out, words[k]);
      end
    end
    test_count++;
    if (level !== '0) begin
      fail_count++;
      $display("[TB] FAIL full_empty_level: got %0d want 0", level);
    end
  endtask

  task automatic test_misalign();
    logic [23:0] exp;
    do_reset();
    queue_frame(24, 1'b0);
    queue_frame(FRAME, 1'b0);
    fill("mis");
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, 1'b0);
      exp = frame_q.pop_front();
      test_count++;
      if (rgb_out !== exp) begin
        fail_count++;
        $display("[TB] FAIL mis_short_pixel: idx %0d rgb=%h want %h", k, rgb_out, exp);
      end
    end
    cycle(1'b1, 1'b0);
    test_count++;
    if (rgb_out !== '0 || locked !== 1'b0 || underflow !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL mis_detect: rgb=%h locked=%b uf=%b want 0/0/0", rgb_out, locked, underflow);
    end
`ifdef VGA_FEEDER_STATS_EN
    test_count++;
    if (resync_cnt !== 16'd1) begin
      fail_count++;
      $display("[TB] FAIL mis_resync_cnt: got %0d want 1", resync_cnt);
    end
`endif
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      cycle(1'b1, 1'b0);
      exp = frame_q.pop_front();
      test_count++;
      if (rgb_out !== exp || locked !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL mis_next_pixel: idx %0d rgb=%h locked=%b want %h/1", k, rgb_out, locked, exp);
      end
    end
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; de = 1'b0; frame_start = 1'b0;
    push_count = 0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_junk();
    test_underflow();
    test_full();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
- Upstream neighbour of the VGA output stage. Buffers a frame-tagged RGB888 pixel stream from the renderer in a FIFO.
- Aligns that stream to the display raster using the timing signals from the VGA stage. Pops one pixel per active-display cycle and presents registered RGB to the VGA output stage.
- Detects underflow and misalignment, then resynchronises on the next start-of-frame.

Parameters:
- DATA_W, 24, pixel width, R in [23:16], G in [15:8], B in [7:0].
- DEPTH, 1024, FIFO entries; must be a power of 2, minimum 4.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.

Ports:
- i_VGA_CLK  in  1  pixel clock; the only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_s_valid  in  1  upstream pixel valid.
- o_s_ready  out  1  upstream ready = FIFO not full.
- i_s_data  in  DATA_W  upstream pixel.
- i_s_sof  in  1  marks the first pixel of a frame; qualified by i_s_valid.
- i_de  in  1  display enable from VGA timing; one pixel requested per high cycle.
- i_frame_start  in  1  one-cycle pulse before the first i_de of a frame.
- o_VGA_R  out  8  red.
- o_VGA_G  out  8  green.
- o_VGA_B  out  8  blue.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_locked  out  1  high while in RUN.
- o_underflow  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - all outputs are 0; FIFO is empty; state = SEARCH; pixel counter = 0.
- Push: occurs when i_s_valid && o_s_ready. Stores {sof, data}.
  - A simultaneous push and pop at full or empty is legal.
  - Pushes are never dropped while o_s_ready is high.
- FIFO is first-word-fall-through. The head word and its sof bit are visible combinationally.
- SEARCH:
  - Pop and discard while the FIFO is non-empty and head sof = 0.
  - Move to WAIT_FRAME when head sof = 1.
- WAIT_FRAME:
  - No pops; RGB = 0.
  - On i_frame_start, move to RUN with pixel counter = 0.
- RUN, on each i_de cycle:
  - If FIFO is empty: underflow. Set o_underflow, output 0, go to SEARCH.
  - Else if head sof = 1 and counter != 0: misaligned. Go to SEARCH without popping, output 0.
  - Else: pop, output the pixel, counter++.
- RUN, on i_frame_start:
  - If counter == H_ACTIVE*V_ACTIVE, or counter == 0: clear counter and stay in RUN.
  - Otherwise: short frame. Go to SEARCH.
- RUN, when counter reaches H_ACTIVE*V_ACTIVE:
  - Any further i_de before i_frame_start is a misalignment. Go to SEARCH.
- Output latency: RGB is registered one cycle after the i_de cycle that popped it. The VGA stage delays its DE/sync by 1 cycle to match.
- RGB is 0 in every cycle where no pop occurred in the previous cycle.
- i_frame_start and i_de in the same cycle: i_frame_start is evaluated first. Counter = 0, then the pop is counted as pixel 1.
- Pixel counter width is $clog2(H_ACTIVE*V_ACTIVE+1); no wrap.
- FIFO pointers are $clog2(DEPTH)+1 bits. Full and empty are decided by the MSB compare.

Optional Feature:
- Macro: VGA_FEEDER_STATS_EN.
- When defined, two extra output ports are added:
  - o_frame_cnt [15:0]: increments on each RUN i_frame_start with counter == H_ACTIVE*V_ACTIVE; wraps.
  - o_resync_cnt [15:0]: increments on each RUN→SEARCH transition; saturates at 16'hFFFF.
- Both counters reset to 0.
- When not defined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Shared package vga_feeder_pkg contains:
  - state enum {SEARCH, WAIT_FRAME, RUN};
  - the pixel_t struct {logic sof; logic [23:0] rgb;};
  - the RGB field slice helpers;
  - constants for default 640x480 timing.
- One sub-module: vga_pixel_fifo, a generic first-word-fall-through synchronous FIFO with level output, instantiated with width DATA_W+1.

Test Plan (bench overrides H_ACTIVE=8, V_ACTIVE=4, DEPTH=16):
1. Reset mid-stream with FIFO holding 5 words → o_level=0, RGB=0, o_locked=0 within the reset cycle; o_s_ready=1 after release.
2. Push 32 pixels (sof on pixel 0, data = index), then frame_start followed by 32 i_de cycles → RGB sequence 0..31, each appearing 1 cycle after its i_de; o_locked=1; o_underflow=0.
3. Push 3 junk pixels (sof=0) then a tagged frame → junk discarded in SEARCH; first displayed pixel = tagged pixel 0.
4. Push only 20 pixels of a frame, then 32 i_de cycles → pixels 0..19 output, then RGB=0; o_underflow=1; state SEARCH; recovers on the next sof frame.
5. Hold i_s_valid=1 with no pops → o_s_ready falls after exactly 16 accepted pushes; o_level=16; no data loss verified on drain.
6. A new sof arrives at the head after 24 pops → state SEARCH without popping, RGB=0; with VGA_FEEDER_STATS_EN, o_resync_cnt=1.
